// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, round constants, forward S-box and word helpers
package aes_pkg;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_t;
  localparam int NR = 10;
  localparam int SCHED_W = 128 * (NR + 1);
  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
endpackage

// File: rtl/aes_key_schedule_if.sv
// aes_key_schedule_if: start/key request and busy/done/schedule response between key schedule and AES core
// signals: KS_START, KS_KEY (to schedule); KS_BUSY, KS_DONE, KS_SCHEDULE (from schedule)
interface aes_key_schedule_if;
  import aes_pkg::*;
  logic KS_START;
  logic [127:0] KS_KEY;
  logic KS_BUSY;
  logic KS_DONE;
  logic [SCHED_W-1:0] KS_SCHEDULE;
  modport master (output KS_START, KS_KEY, input KS_BUSY, KS_DONE, KS_SCHEDULE);
  modport slave (input KS_START, KS_KEY, output KS_BUSY, KS_DONE, KS_SCHEDULE);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box byte substitution
// ports: in_byte (8b) in, out_byte (8b) out
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  assign out_byte = SBOX[in_byte];
endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: sequential AES-128 key expansion, one round key per clock
// ports: CLK, RESET (sync, active high), ks slave modport (KS_START/KS_KEY in, KS_BUSY/KS_DONE/KS_SCHEDULE out)
module aes_key_schedule #(
  parameter int NR = aes_pkg::NR
) (
  input logic CLK,
  input logic RESET,
  aes_key_schedule_if.slave ks
);
  import aes_pkg::*;
  if (NR != 10) begin : g_bad_nr
    $error("aes_key_schedule supports only NR=10");
  end
  ks_state_t state, nxt;
  logic [3:0] ctr;
  logic [127:0] w, nw;
  logic [127:0] rk [0:NR];
  logic [31:0] rw, sw, temp;
  assign rw = rot_word(w[31:0]);
  for (genvar j = 0; j < 4; j++) begin : g_sub
    aes_sbox u_sbox (.in_byte(rw[8*j +: 8]), .out_byte(sw[8*j +: 8]));
  end
  assign temp = sw ^ {RCON[ctr], 24'h0};
  assign nw[127:96] = w[127:96] ^ temp;
  assign nw[95:64] = w[95:64] ^ nw[127:96];
  assign nw[63:32] = w[63:32] ^ nw[95:64];
  assign nw[31:0] = w[31:0] ^ nw[63:32];
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (ks.KS_START ? EXPAND : IDLE) :
          state == EXPAND ? (ctr == 4'(NR) ? DONE : EXPAND) :
          (ks.KS_START ? DONE : IDLE);
  end
  always_ff @(posedge CLK)
    if (RESET) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctr <= '0;
      w <= '0;
      for (int r = 0; r <= NR; r++) rk[r] <= '0;
    end else if (state == IDLE && ks.KS_START) begin
      ctr <= 4'd1;
      w <= ks.KS_KEY;
      rk[0] <= ks.KS_KEY;
      for (int r = 1; r <= NR; r++) rk[r] <= '0;
    end else if (state == EXPAND) begin
      ctr <= ctr + 4'd1;
      w <= nw;
      rk[ctr] <= nw;
    end
  end
  assign ks.KS_BUSY = state == EXPAND;
  assign ks.KS_DONE = state == DONE;
  for (genvar r = 0; r <= NR; r++) begin : g_sched
    assign ks.KS_SCHEDULE[SCHED_W-1-128*r -: 128] = rk[r];
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed FIPS-197 vectors against the sequential AES-128 key schedule
module tb_aes_key_schedule;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int total = 0;
  int bad = 0;
  int n;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K3_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K3_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K0_R1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K0_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  always #5 CLK = ~CLK;
  aes_key_schedule_if ks();
  aes_key_schedule dut (.CLK(CLK), .RESET(RESET), .ks(ks));
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [1407:0] got, input logic [1407:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] rk(input int r);
    return ks.KS_SCHEDULE[1407-128*r -: 128];
  endfunction
  task automatic expand(input logic [127:0] key, output int edges);
    ks.KS_KEY = key;
    ks.KS_START = 1'b1;
    tick();
    edges = 0;
    while (!ks.KS_DONE && edges < 20) begin
      tick();
      edges++;
    end
  endtask
  initial begin
    ks.KS_START = 1'b0;
    ks.KS_KEY = '0;
    tick();
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_sched", ks.KS_SCHEDULE, '0);
      chk("t1_done", ks.KS_DONE, 0);
      chk("t1_busy", ks.KS_BUSY, 0);
    end
    ks.KS_KEY = K2;
    ks.KS_START = 1'b1;
    tick();
    chk("t2_busy0", ks.KS_BUSY, 1);
    chk("t2_r0", rk(0), K2);
    for (int e = 1; e <= 10; e++) begin
      if (e == 3) ks.KS_START = 1'b0;
      tick();
      chk($sformatf("t2_done_e%0d", e), ks.KS_DONE, e == 10);
    end
    chk("t2_r1", rk(1), K2_R1);
    chk("t2_r10", rk(10), K2_R10);
    tick();
    chk("t2_done_fall", ks.KS_DONE, 0);
    chk("t2_r10_kept", rk(10), K2_R10);
    expand(K3, n);
    chk("t3_lat", n, 10);
    chk("t3_r0", rk(0), K3);
    chk("t3_r1", rk(1), K3_R1);
    chk("t3_r10", rk(10), K3_R10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_done", ks.KS_DONE, 1);
      chk("t3_hold_busy", ks.KS_BUSY, 0);
      chk("t3_hold_r1", rk(1), K3_R1);
      chk("t3_hold_r10", rk(10), K3_R10);
    end
    ks.KS_START = 1'b0;
    tick();
    chk("t3_idle", ks.KS_DONE, 0);
    expand('0, n);
    chk("t4_lat", n, 10);
    chk("t4_r0", rk(0), '0);
    chk("t4_r1", rk(1), K0_R1);
    chk("t4_r10", rk(10), K0_R10);
    ks.KS_START = 1'b0;
    tick();
    ks.KS_KEY = K2;
    ks.KS_START = 1'b1;
    tick();
    ks.KS_START = 1'b0;
    for (int e = 1; e <= 3; e++) tick();
    ks.KS_KEY = '1;
    n = 3;
    while (!ks.KS_DONE && n < 20) begin
      tick();
      n++;
    end
    chk("t5_lat", n, 10);
    chk("t5_r0", rk(0), K2);
    chk("t5_r1", rk(1), K2_R1);
    chk("t5_r10", rk(10), K2_R10);
    tick();
    ks.KS_KEY = K3;
    ks.KS_START = 1'b1;
    tick();
    for (int e = 1; e <= 5; e++) tick();
    chk("t6_busy_pre", ks.KS_BUSY, 1);
    RESET = 1'b1;
    tick();
    chk("t6_sched", ks.KS_SCHEDULE, '0);
    chk("t6_busy", ks.KS_BUSY, 0);
    chk("t6_done", ks.KS_DONE, 0);
    RESET = 1'b0;
    ks.KS_START = 1'b0;
    tick();
    chk("t6_idle_busy", ks.KS_BUSY, 0);
    expand(K2, n);
    chk("t6_lat", n, 10);
    chk("t6_r0", rk(0), K2);
    chk("t6_r1", rk(1), K2_R1);
    chk("t6_r10", rk(10), K2_R10);
    ks.KS_START = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
